tg_debug_port: RTL

// Target-side responder for the supervisor (visor) debug interface. Sits between the target CPU
// and its code ROM, and answers visor register writes. It provides:
// - 4 hardware breakpoints that halt target fetch.
// - Code-bus diversion so the visor can inject instructions.
// - Forced exr load/execute strobes.
// - exr shadow capture.
// - A target->visor data register written by target r15.

---
 rtl/visor_debug_pkg.sv | 31 +++
 rtl/tg_bp_unit.sv | 79 +++++++
 rtl/tg_debug_port.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/visor_debug_pkg.sv
// Shared constants for the visor debug interface: register select codes,
// control bit positions, the target-side FSM encoding and the disabled-breakpoint value.
package visor_debug_pkg;

    // visor_wr_sel codes
    localparam logic [2:0] SEL_BP0        = 3'd0;
    localparam logic [2:0] SEL_BP1        = 3'd1;
    localparam logic [2:0] SEL_BP2        = 3'd2;
    localparam logic [2:0] SEL_BP3        = 3'd3;
    localparam logic [2:0] SEL_BUS_CTRL   = 3'd4;
    localparam logic [2:0] SEL_TG_FORCE   = 3'd5;
    localparam logic [2:0] SEL_TG_CODE_IN = 3'd6;

    // bus_ctrl bit positions
    localparam int unsigned BUS_TG_RESET = 1;
    localparam int unsigned BUS_DIVERT   = 2;

    // tg_force bit positions
    localparam int unsigned FORCE_HOLD     = 0;
    localparam int unsigned FORCE_LOAD_EXR = 1;
    localparam int unsigned FORCE_EXEC     = 2;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } tg_state_e;

    // Breakpoint value that never matches
    localparam logic [15:0] BP_DISABLE_DEFAULT = 16'hffff;

endpackage

// File: rtl/tg_bp_unit.sv
// One hardware breakpoint: address register, hit status and pass-once flag.
// Ports: clk/rst_n (sync, active low); wr_en/wdata load the address;
// clr drops status and pass-once (target reset); arm enables matching;
// fetch_addr/exr_load observe target fetches; addr_q/status_q readback;
// match_c is the combinational qualified match for this breakpoint.
module tg_bp_unit
    import visor_debug_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] BP_DISABLE = ADDR_W'(BP_DISABLE_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wdata,
    input  logic              clr,
    input  logic              arm,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              exr_load,
    output logic [ADDR_W-1:0] addr_q,
    output logic              status_q,
    output logic              match_c
);

    logic [ADDR_W-1:0] addr_d;
    logic              status_d;
    logic              pass_d;
    logic              pass_q;
    logic              hit_c;

    assign hit_c   = exr_load & (fetch_addr == addr_q) & (addr_q != BP_DISABLE);
    // A concurrent visor write to this breakpoint suppresses its match
    assign match_c = hit_c & ~pass_q & arm & ~wr_en;

    // Next-state: fetch events first, visor write overrides, target reset overrides all
    always_comb begin
        addr_d   = addr_q;
        status_d = status_q;
        pass_d   = pass_q;

        if (hit_c) begin
            pass_d = 1'b0;
        end
        if (match_c) begin
            status_d = 1'b1;
        end
        if (wr_en) begin
            addr_d   = wdata;
            status_d = 1'b0;
            if (wdata == BP_DISABLE) begin
                pass_d = 1'b0;
            end else if (wdata == addr_q) begin
                // Re-arming the address that just hit steps over it once
                if (status_q) begin
                    pass_d = 1'b1;
                end
            end else begin
                pass_d = 1'b0;
            end
        end
        if (clr) begin
            status_d = 1'b0;
            pass_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q   <= BP_DISABLE;
            status_q <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            status_q <= status_d;
            pass_q   <= pass_d;
        end
    end

endmodule

// File: rtl/tg_debug_port.sv
// Target-side debug responder: breakpoints that halt fetch, code-bus diversion,
// forced exr load/exec strobes, exr shadow capture and a target->visor data register.
// Ports: sysclk/sysreset_n (sync, active low); visor_wr_* register writes;
// bp_addr_q/bp_status/exr_shadow/tg_to_visor_reg readback; tg_fetch_addr/tg_exr_load/
// tg_code_rom/tg_r15_* from the target side; tg_code_out/tg_reset/tg_hold/
// tg_force_load_exr/tg_force_exec drive the target.
module tg_debug_port
    import visor_debug_pkg::*;
#(
    parameter int unsigned       NUM_BP     = 4,
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       DATA_W     = 16,
    parameter logic [ADDR_W-1:0] BP_DISABLE = ADDR_W'(BP_DISABLE_DEFAULT)
) (
    input  logic                     sysclk,
    input  logic                     sysreset_n,
    input  logic                     visor_wr_en,
    input  logic [2:0]               visor_wr_sel,
    input  logic [DATA_W-1:0]        visor_wdata,
    output logic [NUM_BP*ADDR_W-1:0] bp_addr_q,
    output logic [NUM_BP-1:0]        bp_status,
    output logic [DATA_W-1:0]        exr_shadow,
    output logic [DATA_W-1:0]        tg_to_visor_reg,
    input  logic [ADDR_W-1:0]        tg_fetch_addr,
    input  logic                     tg_exr_load,
    input  logic [DATA_W-1:0]        tg_code_rom,
    output logic [DATA_W-1:0]        tg_code_out,
    input  logic                     tg_r15_wr,
    input  logic [DATA_W-1:0]        tg_r15_data,
    output logic                     tg_reset,
    output logic                     tg_hold,
    output logic                     tg_force_load_exr,
    output logic                     tg_force_exec
);

    tg_state_e         state_q, state_d;
    logic              tg_reset_q, tg_reset_d;
    logic              divert_q, divert_d;
    logic              force_hold_q, force_hold_d;
    logic [DATA_W-1:0] code_in_q, code_in_d;
    logic              load_pulse_q, load_pulse_d;
    logic              exec_pulse_q, exec_pulse_d;
    logic              hold_q, hold_d;
    logic [DATA_W-1:0] exr_shadow_q, exr_shadow_d;
    logic [DATA_W-1:0] to_visor_q, to_visor_d;
    logic [NUM_BP-1:0] match_c;
    logic              arm_c;

    // Matching only while running freely: not in target reset, not force-held
    assign arm_c = (state_q == ST_RUN) & ~tg_reset_q & ~force_hold_q;

    for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
        tg_bp_unit #(
            .ADDR_W     (ADDR_W),
            .BP_DISABLE (BP_DISABLE)
        ) u_bp (
            .clk        (sysclk),
            .rst_n      (sysreset_n),
            .wr_en      (visor_wr_en & (visor_wr_sel == 3'(i))),
            .wdata      (ADDR_W'(visor_wdata)),
            .clr        (tg_reset_q),
            .arm        (arm_c),
            .fetch_addr (tg_fetch_addr),
            .exr_load   (tg_exr_load),
            .addr_q     (bp_addr_q[i*ADDR_W +: ADDR_W]),
            .status_q   (bp_status[i]),
            .match_c    (match_c[i])
        );
    end

    // FSM, control registers, force pulses and capture registers
    always_comb begin
        state_d      = state_q;
        tg_reset_d   = tg_reset_q;
        divert_d     = divert_q;
        force_hold_d = force_hold_q;
        code_in_d    = code_in_q;
        load_pulse_d = 1'b0;
        exec_pulse_d = 1'b0;
        exr_shadow_d = exr_shadow_q;
        to_visor_d   = to_visor_q;

        if (visor_wr_en) begin
            case (visor_wr_sel)
                SEL_BUS_CTRL: begin
                    tg_reset_d = visor_wdata[BUS_TG_RESET];
                    divert_d   = visor_wdata[BUS_DIVERT];
                end
                SEL_TG_FORCE: begin
                    force_hold_d = visor_wdata[FORCE_HOLD];
                    load_pulse_d = visor_wdata[FORCE_LOAD_EXR];
                    exec_pulse_d = visor_wdata[FORCE_EXEC];
                end
                SEL_TG_CODE_IN: code_in_d = visor_wdata;
                default: ;
            endcase
        end

        if (tg_reset_q) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (|match_c) begin
                        state_d      = ST_HALTED;
                        exr_shadow_d = tg_code_rom;
                    end
                end
                ST_HALTED: begin
                    if (bp_status == '0) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        hold_d = (state_d == ST_HALTED) | force_hold_d;

        if (tg_r15_wr) begin
            to_visor_d = tg_r15_data;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            state_q      <= ST_RUN;
            tg_reset_q   <= 1'b0;
            divert_q     <= 1'b0;
            force_hold_q <= 1'b0;
            code_in_q    <= '0;
            load_pulse_q <= 1'b0;
            exec_pulse_q <= 1'b0;
            hold_q       <= 1'b0;
            exr_shadow_q <= '0;
            to_visor_q   <= '0;
        end else begin
            state_q      <= state_d;
            tg_reset_q   <= tg_reset_d;
            divert_q     <= divert_d;
            force_hold_q <= force_hold_d;
            code_in_q    <= code_in_d;
            load_pulse_q <= load_pulse_d;
            exec_pulse_q <= exec_pulse_d;
            hold_q       <= hold_d;
            exr_shadow_q <= exr_shadow_d;
            to_visor_q   <= to_visor_d;
        end
    end

    // Code bus diversion is a pure mux so ROM data passes through without latency
    assign tg_code_out       = divert_q ? code_in_q : tg_code_rom;
    assign tg_reset          = tg_reset_q;
    assign tg_hold           = hold_q;
    assign tg_force_load_exr = load_pulse_q;
    assign tg_force_exec     = exec_pulse_q;
    assign exr_shadow        = exr_shadow_q;
    assign tg_to_visor_reg   = to_visor_q;

endmodule
